// File: rtl/counter_scheduler_pkg.sv
// Purpose: shared widths, FSM state encoding and command payload for the
//          counter scheduler slice.
// Contents: LEN_W/CNT_W/NREQ widths, state_e, cmd_t {down, step, len}.
package counter_scheduler_pkg;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic             down;
        logic             step;
        logic [LEN_W-1:0] len;
    } cmd_t;

endpackage

// File: rtl/counter_scheduler_if.sv
// Purpose: requester-side bus of the counter scheduler.
// Signals: req_valid/req_ready handshake per requester, command fields
//          req_down/req_step/req_len, and scheduler status q/busy/owner/done.
// Modports: master = requesters/consumer, slave = scheduler.
interface counter_scheduler_if;
    import counter_scheduler_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_down;
    logic [NREQ-1:0]       req_step;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [CNT_W-1:0]      q;
    logic                  busy;
    logic                  owner;
    logic [NREQ-1:0]       done;

    modport master (
        output req_valid, req_down, req_step, req_len,
        input  req_ready, q, busy, owner, done
    );

    modport slave (
        input  req_valid, req_down, req_step, req_len,
        output req_ready, q, busy, owner, done
    );

endinterface

// File: rtl/counter_scheduler_step_counter.sv
// Purpose: W-bit up/down counter, step 1 or 2, wrapping mod 2**W.
// Ports: clk, rst (sync active-high), en (advance this edge), down (1 = count
//        down), step (1 = +/-2, 0 = +/-1), q (registered count).
module step_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         down,
    input  logic         step,
    output logic [W-1:0] q
);

    logic [W-1:0] inc;

    always_comb begin
        inc = step ? W'(2) : W'(1);
    end

    // Natural modular wrap; a step of 2 never touches q[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= down ? (q - inc) : (q + inc);
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Purpose: round-robin scheduler sharing one step_counter between two
//          requesters; each accepted burst enables the counter for len edges.
// Ports: clk, rst (sync active-high), bus (counter_scheduler_if.slave):
//        req_valid/req_ready handshake (req_ready combinational, IDLE only),
//        req_down/req_step/req_len command fields, q counter value,
//        busy (RUN or DONE), owner (served requester), done (1-cycle pulse).
module counter_scheduler
    import counter_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    counter_scheduler_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             rr;
    logic             owner_r;
    logic             cmd_down;
    logic             cmd_step;
    logic [LEN_W-1:0] rem;
    logic             gidx;
    logic [NREQ-1:0]  ready_c;
    logic             accept;
    cmd_t             sel_cmd;
    logic [CNT_W-1:0] q_w;

    // Grant selection: sole valid requester, otherwise the rr-preferred one.
    always_comb begin
        gidx = rr;
        if (bus.req_valid == 2'b01) begin
            gidx = 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            gidx = 1'b1;
        end
        sel_cmd.down = bus.req_down[gidx];
        sel_cmd.step = bus.req_step[gidx];
        sel_cmd.len  = gidx ? bus.req_len[LEN_W +: LEN_W] : bus.req_len[0 +: LEN_W];
    end

    // Next state and combinational ready; reset suppresses any grant.
    always_comb begin
        state_nxt = state;
        ready_c   = '0;
        case (state)
            S_IDLE: begin
                if (!rst && (bus.req_valid != '0)) begin
                    ready_c[gidx] = 1'b1;
                    state_nxt     = (sel_cmd.len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (rem == LEN_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign accept = (ready_c != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched command, owner, rr pointer and remaining tick count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= 1'b0;
            owner_r  <= 1'b0;
            cmd_down <= 1'b0;
            cmd_step <= 1'b0;
            rem      <= '0;
        end else if (accept) begin
            rr       <= ~gidx;
            owner_r  <= gidx;
            cmd_down <= sel_cmd.down;
            cmd_step <= sel_cmd.step;
            rem      <= sel_cmd.len;
        end else if (state == S_RUN) begin
            rem <= rem - LEN_W'(1);
        end
    end

    step_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (state == S_RUN),
        .down (cmd_down),
        .step (cmd_step),
        .q    (q_w)
    );

    assign bus.q         = q_w;
    assign bus.req_ready = ready_c;
    assign bus.busy      = (state != S_IDLE);
    assign bus.owner     = owner_r;
    assign bus.done      = (state == S_DONE) ? (owner_r ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_counter_scheduler.sv
// Purpose: self-checking bench for counter_scheduler against a transaction-
//          level model (expected q from q0 + k*delta mod 16, fixed latencies).
module tb_counter_scheduler;

    logic clk = 1'b0;
    logic rst;

    counter_scheduler_if bus();

    counter_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mq     = 0;   // expected counter value while idle
    int mrr    = 0;   // expected preferred requester

    function automatic int wrap16(input int x);
        return ((x % 16) + 16) % 16;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One burst from requester r alone; checks the whole timeline to IDLE.
    task automatic do_burst(input int r, input bit dn, input bit st, input int n);
        int d;
        int o;
        d = (dn ? -1 : 1) * (st ? 2 : 1);
        o = 1 << r;
        bus.req_down[r]        = dn;
        bus.req_step[r]        = st;
        bus.req_len[r*4 +: 4]  = 4'(n);
        bus.req_valid          = 2'(o);
        #1;
        checks++; if (bus.req_ready !== 2'(o)) begin errors++; $display("FAIL ready_idle: got %b want %b", bus.req_ready, 2'(o)); end
        tick();
        bus.req_valid         = '0;
        bus.req_down[r]       = ~dn;
        bus.req_step[r]       = ~st;
        bus.req_len[r*4 +: 4] = 4'($urandom);
        checks++; if (bus.owner !== 1'(r) || bus.busy !== 1'b1) begin errors++; $display("FAIL owner_busy: got owner=%0d busy=%b want owner=%0d busy=1", bus.owner, bus.busy, r); end
        checks++; if (bus.done !== 2'((n == 0) ? o : 0)) begin errors++; $display("FAIL done_after_accept: got %b want %b", bus.done, 2'((n == 0) ? o : 0)); end
        checks++; if (bus.q !== 4'(mq)) begin errors++; $display("FAIL q_accept_edge: got %0d want %0d", bus.q, mq); end
        for (int k = 1; k <= n; k++) begin
            tick();
            checks++; if (bus.q !== 4'(wrap16(mq + k * d))) begin errors++; $display("FAIL q_run k=%0d: got %0d want %0d", k, bus.q, wrap16(mq + k * d)); end
            checks++; if (bus.done !== 2'((k == n) ? o : 0) || bus.busy !== 1'b1 || bus.req_ready !== 2'b00) begin
                errors++; $display("FAIL run_status k=%0d: got done=%b busy=%b ready=%b want done=%b busy=1 ready=00", k, bus.done, bus.busy, bus.req_ready, 2'((k == n) ? o : 0));
            end
        end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.q !== 4'(wrap16(mq + n * d))) begin
            errors++; $display("FAIL back_idle: got busy=%b done=%b q=%0d want busy=0 done=00 q=%0d", bus.busy, bus.done, bus.q, wrap16(mq + n * d));
        end
        mq  = wrap16(mq + n * d);
        mrr = 1 - r;
    endtask

    // Walk q upward by ones to a target value using requester 0.
    task automatic goto_q(input int target);
        do_burst(0, 1'b0, 1'b0, wrap16(target - mq));
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_down  = '0;
        bus.req_step  = '0;
        bus.req_len   = 8'h33;
        tick();
        tick();
        bus.req_valid = '0;
        rst           = 1'b0;
        #1;
        checks++; if (bus.q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", bus.q); end
        checks++; if (bus.busy !== 1'b0 || bus.owner !== 1'b0 || bus.done !== 2'b00) begin
            errors++; $display("FAIL reset_status: got busy=%b owner=%b done=%b want 0/0/00", bus.busy, bus.owner, bus.done);
        end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
        mq  = 0;
        mrr = 0;
    endtask

    task automatic test_basic();
        do_burst(0, 1'b0, 1'b0, 5);
    endtask

    task automatic test_wrap();
        goto_q(14);
        do_burst(1, 1'b0, 1'b1, 2);
        do_burst(1, 1'b1, 1'b1, 2);
    endtask

    task automatic test_odd_step2();
        goto_q(1);
        do_burst(0, 1'b1, 1'b1, 1);
        checks++; if (bus.q[0] !== 1'b1) begin errors++; $display("FAIL odd_lsb: got %b want 1", bus.q[0]); end
    endtask

    task automatic test_len0();
        goto_q(7);
        do_burst(0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int p;
        int d;
        bit dn [2];
        bit st [2];
        p = mrr;
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 2; i++) begin
                dn[i] = 1'($urandom);
                st[i] = 1'($urandom);
            end
            bus.req_down  = {dn[1], dn[0]};
            bus.req_step  = {st[1], st[0]};
            bus.req_len   = {4'd1, 4'd1};
            bus.req_valid = 2'b11;
            #1;
            checks++; if (bus.req_ready !== 2'(1 << p)) begin errors++; $display("FAIL b2b_ready g=%0d: got %b want %b", g, bus.req_ready, 2'(1 << p)); end
            tick();
            bus.req_down = 2'($urandom);
            bus.req_step = 2'($urandom);
            bus.req_len  = 8'($urandom);
            checks++; if (bus.owner !== 1'(p) || bus.req_ready !== 2'b00) begin
                errors++; $display("FAIL b2b_owner g=%0d: got owner=%b ready=%b want owner=%0d ready=00", g, bus.owner, bus.req_ready, p);
            end
            d = (dn[p] ? -1 : 1) * (st[p] ? 2 : 1);
            tick();
            checks++; if (bus.q !== 4'(wrap16(mq + d)) || bus.done !== 2'(1 << p)) begin
                errors++; $display("FAIL b2b_q_done g=%0d: got q=%0d done=%b want q=%0d done=%b", g, bus.q, bus.done, wrap16(mq + d), 2'(1 << p));
            end
            tick();
            checks++; if (bus.done !== 2'b00 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL b2b_idle g=%0d: got done=%b busy=%b want 00/0", g, bus.done, bus.busy);
            end
            mq = wrap16(mq + d);
            p  = 1 - p;
        end
        bus.req_valid = '0;
        mrr = p;
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            do_burst(int'($urandom_range(1, 0)), 1'($urandom), 1'($urandom), int'($urandom_range(15, 0)));
        end
    endtask

    task automatic test_rst_mid();
        bus.req_down[0]   = 1'b0;
        bus.req_step[0]   = 1'b0;
        bus.req_len[3:0]  = 4'd8;
        bus.req_valid     = 2'b01;
        #1;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        checks++; if (bus.q !== 4'(wrap16(mq + 2)) || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got q=%0d busy=%b want q=%0d busy=1", bus.q, bus.busy, wrap16(mq + 2));
        end
        rst            = 1'b1;
        bus.req_valid  = 2'b10;
        bus.req_len    = 8'h30;
        tick();
        rst           = 1'b0;
        bus.req_valid = '0;
        #1;
        checks++; if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
            errors++; $display("FAIL rst_mid_post: got q=%0d busy=%b done=%b want 0/0/00", bus.q, bus.busy, bus.done);
        end
        mq  = 0;
        mrr = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.done !== 2'b00 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL rst_no_done k=%0d: got done=%b busy=%b want 00/0", k, bus.done, bus.busy);
            end
        end
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rst_rr: got %b want 01", bus.req_ready); end
        bus.req_valid = '0;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_down  = '0;
        bus.req_step  = '0;
        bus.req_len   = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_odd_step2();
        test_len0();
        test_back_to_back();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
